// File: rtl/serial_addsub_param.sv
// serial_addsub_param: multi-bit-per-cycle serial adder/subtractor
// Successor to the 8-bit bit-serial adder; LSB-first, DIGIT bits per cycle.
//
// Purpose
//   Adds or subtracts two WIDTH-bit operands in WIDTH/DIGIT cycles, one
//   DIGIT-bit slice per cycle, with carry-in for multi-word chaining and
//   signed-overflow detection. Valid/ready handshake on both sides.
//
// Parameters
//   WIDTH      operand/result width (WIDTH % DIGIT == 0)
//   DIGIT      bits processed per RUN cycle (1..WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operands/mode/cin valid
//   in_ready   operands accepted this cycle (IDLE only)
//   a, b       operands
//   sub        0: a+b+cin, 1: a-b (cin ignored)
//   cin        carry-in for add mode
//   abort      synchronous abort back to IDLE, clears result
//   out_valid  result valid (DONE)
//   out_ready  downstream takes the result
//   sum        result, modulo 2^WIDTH
//   cout       carry-out; in sub mode 1 means no borrow
//   ovf        signed overflow

module serial_addsub_param #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / DIGIT;
   localparam int CNT_W  = $clog2(NSLICE) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry;
   logic [CNT_W-1:0] count;

   logic             accept;
   logic             last_slice;

   logic [DIGIT:0]   c;
   logic [DIGIT-1:0] s;
   logic [WIDTH-1:0] slice_ext;
   logic [WIDTH-1:0] sum_shift;

   assign accept     = (state == IDLE) && in_valid && !abort;
   assign last_slice = (state == RUN) && (count == LAST);

   // Ripple across the slice; c[DIGIT-1] is the carry into the slice MSB,
   // which on the final slice is the carry into bit WIDTH-1.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = carry;
      for (int i = 0; i < DIGIT; i++) begin
         s[i]   = a_reg[i] ^ b_reg[i] ^ c[i];
         c[i+1] = (a_reg[i] & b_reg[i]) |
                  (c[i] & (a_reg[i] ^ b_reg[i]));
      end
   end

   // New slice enters from the MSB side so after NSLICE shifts the
   // first slice has reached bit 0.
   assign slice_ext = WIDTH'(s) << (WIDTH - DIGIT);
   assign sum_shift = (sum >> DIGIT) | slice_ext;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_nx = IDLE;
            end else if (last_slice) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (abort || out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   // Datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         carry <= 1'b0;
         count <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_reg <= a;
                  b_reg <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  count <= '0;
               end
            end
            RUN: begin
               if (abort) begin
                  carry <= 1'b0;
                  count <= '0;
                  sum   <= '0;
                  cout  <= 1'b0;
                  ovf   <= 1'b0;
               end else begin
                  a_reg <= a_reg >> DIGIT;
                  b_reg <= b_reg >> DIGIT;
                  carry <= c[DIGIT];
                  count <= count + 1'b1;
                  sum   <= sum_shift;
                  if (last_slice) begin
                     cout <= c[DIGIT];
                     ovf  <= c[DIGIT] ^ c[DIGIT-1];
                  end
               end
            end
            DONE: begin
               if (abort) begin
                  sum  <= '0;
                  cout <= 1'b0;
                  ovf  <= 1'b0;
               end
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_param.sv
// tb_serial_addsub_param: directed and randomized bench for
// serial_addsub_param (W16/D2 main instance, D1/D4/D16 sweep instances).

module tb_serial_addsub_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        sub;
   logic        cin;
   logic        abort;
   logic        out_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   logic        sw_in_valid;
   logic [2:0]  sw_out_ready;
   logic [2:0]  sw_in_ready;
   logic [2:0]  sw_out_valid;
   logic [2:0]  sw_cout;
   logic [2:0]  sw_ovf;
   logic [15:0] sw_sum [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_addsub_param #(.WIDTH(16), .DIGIT(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin), .abort(abort),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_addsub_param #(.WIDTH(16), .DIGIT(1)) dut_d1 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid),
      .in_ready(sw_in_ready[0]), .a(a), .b(b), .sub(sub), .cin(cin),
      .abort(abort), .out_valid(sw_out_valid[0]),
      .out_ready(sw_out_ready[0]), .sum(sw_sum[0]),
      .cout(sw_cout[0]), .ovf(sw_ovf[0])
   );

   serial_addsub_param #(.WIDTH(16), .DIGIT(4)) dut_d4 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid),
      .in_ready(sw_in_ready[1]), .a(a), .b(b), .sub(sub), .cin(cin),
      .abort(abort), .out_valid(sw_out_valid[1]),
      .out_ready(sw_out_ready[1]), .sum(sw_sum[1]),
      .cout(sw_cout[1]), .ovf(sw_ovf[1])
   );

   serial_addsub_param #(.WIDTH(16), .DIGIT(16)) dut_d16 (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid),
      .in_ready(sw_in_ready[2]), .a(a), .b(b), .sub(sub), .cin(cin),
      .abort(abort), .out_valid(sw_out_valid[2]),
      .out_ready(sw_out_ready[2]), .sum(sw_sum[2]),
      .cout(sw_cout[2]), .ovf(sw_ovf[2])
   );

   // Accept one operand set on the main DUT and count edges until
   // out_valid; lat = -1 if it never shows up within the budget.
   task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, input logic tc, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic finish_txn;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; sub = 1'b0; cin = 1'b0; abort = 1'b0;
      out_ready = 1'b0; a = '0; b = '0;
      sw_in_valid = 1'b0; sw_out_ready = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      n_checks++;
      if (sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out: sum=%h cout=%b ovf=%b expected 0000/0/0", sum, cout, ovf);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_add;
      int lat;
      run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
      n_checks++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL add_latency: got %0d expected 8", lat);
      end
      n_checks++;
      if (sum !== 16'h8000 || cout !== 1'b0 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL add_result: sum=%h cout=%b ovf=%b expected 8000/0/1", sum, cout, ovf);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL add_in_ready_done: got %b expected 0", in_ready);
      end
      finish_txn();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL add_handshake: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_wrap;
      int lat;
      run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
      n_checks++;
      if (lat !== 8 || sum !== 16'h0000 || cout !== 1'b1 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_cin0: lat=%0d sum=%h cout=%b ovf=%b expected 8/0000/1/0", lat, sum, cout, ovf);
      end
      finish_txn();
      run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b1, lat);
      n_checks++;
      if (lat !== 8 || sum !== 16'h0001 || cout !== 1'b1 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_cin1: lat=%0d sum=%h cout=%b ovf=%b expected 8/0001/1/0", lat, sum, cout, ovf);
      end
      finish_txn();
   endtask

   task automatic test_sub;
      int lat;
      run_txn(16'h0003, 16'h0005, 1'b1, 1'b0, lat);
      n_checks++;
      if (lat !== 8 || sum !== 16'hFFFE || cout !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_borrow: lat=%0d sum=%h cout=%b ovf=%b expected 8/fffe/0/0", lat, sum, cout, ovf);
      end
      finish_txn();
      run_txn(16'h8000, 16'h0001, 1'b1, 1'b0, lat);
      n_checks++;
      if (sum !== 16'h7FFF || cout !== 1'b1 || ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b expected 7fff/1/1", sum, cout, ovf);
      end
      finish_txn();
      // cin must be ignored in subtract mode
      run_txn(16'h0003, 16'h0005, 1'b1, 1'b1, lat);
      n_checks++;
      if (sum !== 16'hFFFE || cout !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_cin_ignored: sum=%h cout=%b expected fffe/0", sum, cout);
      end
      finish_txn();
   endtask

   task automatic test_backpressure;
      int lat;
      logic seen;
      // operand inputs are scrambled during RUN and must not matter
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1; cin = 1'b1;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      n_checks++;
      if (lat !== 8 || sum !== 16'h2345 || cout !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_result: lat=%0d sum=%h cout=%b ovf=%b expected 8/2345/0/0", lat, sum, cout, ovf);
      end
      in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (sum !== 16'h2345 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: sum=%h out_valid=%b in_ready=%b expected 2345/1/0", i, sum, out_valid, in_ready);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | out_valid | !in_ready;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_no_accept: busy_seen=%b expected 0", seen);
      end
   endtask

   task automatic test_abort;
      int lat;
      logic seen;
      // abort mid-RUN at count 3
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_run: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b expected 1/0/0000/0/0", in_ready, out_valid, sum, cout, ovf);
      end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_run_no_valid: out_valid_seen=%b expected 0", seen);
      end
      // abort in IDLE blocks the accept
      a = 16'h0001; b = 16'h0001; in_valid = 1'b1; abort = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; abort = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_idle_block: in_ready=%b expected 1", in_ready);
      end
      // abort in DONE clears the held result
      run_txn(16'h0101, 16'h0202, 1'b0, 1'b0, lat);
      n_checks++;
      if (sum !== 16'h0303 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_done_pre: sum=%h out_valid=%b expected 0303/1", sum, out_valid);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0) begin
         n_fail++;
         $display("FAIL abort_done: out_valid=%b in_ready=%b sum=%h expected 0/1/0000", out_valid, in_ready, sum);
      end
   endtask

   task automatic test_reset_midrun;
      logic seen;
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_midrun: in_ready=%b out_valid=%b sum=%h cout=%b expected 1/0/0000/0", in_ready, out_valid, sum, cout);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         seen = seen | out_valid | !in_ready;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_midrun_idle: busy_seen=%b expected 0", seen);
      end
   endtask

   task automatic test_param_sweep;
      logic [15:0] ra, rb, bb;
      logic        rs, rc, ci, eo;
      logic [16:0] full;
      int          lat [3];
      int          exp_lat [3];
      int          cnt;
      exp_lat = '{16, 4, 1};
      for (int v = 0; v < 1000; v++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         bb   = rs ? ~rb : rb;
         ci   = rs ? 1'b1 : rc;
         full = {1'b0, ra} + {1'b0, bb} + {16'h0, ci};
         eo   = (ra[15] == bb[15]) && (full[15] != ra[15]);
         @(negedge clk);
         a = ra; b = rb; sub = rs; cin = rc; sw_in_valid = 1'b1;
         @(posedge clk);
         @(negedge clk);
         sw_in_valid = 1'b0;
         lat = '{-1, -1, -1};
         cnt = 0;
         while (cnt < 40) begin
            for (int i = 0; i < 3; i++) begin
               if (sw_out_valid[i] && lat[i] < 0) lat[i] = cnt;
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
            @(negedge clk);
            cnt++;
         end
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lat[i] !== exp_lat[i]) begin
               n_fail++;
               $display("FAIL sweep_lat[%0d] v%0d: got %0d expected %0d", i, v, lat[i], exp_lat[i]);
            end
            n_checks++;
            if (sw_sum[i] !== full[15:0] || sw_cout[i] !== full[16] || sw_ovf[i] !== eo) begin
               n_fail++;
               $display("FAIL sweep_res[%0d] v%0d a=%h b=%h sub=%b cin=%b: sum=%h cout=%b ovf=%b expected %h/%b/%b", i, v, ra, rb, rs, rc, sw_sum[i], sw_cout[i], sw_ovf[i], full[15:0], full[16], eo);
            end
         end
         sw_out_ready = 3'b111;
         @(negedge clk);
         sw_out_ready = 3'b000;
         n_checks++;
         if (sw_in_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL sweep_idle v%0d: in_ready=%b expected 111", v, sw_in_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_wrap();
      test_sub();
      test_backpressure();
      test_abort();
      test_reset_midrun();
      test_param_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
